// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared combinational
// ALU. Latches the winner's operands, waits SETTLE_CYCLES for the ALU to
// settle, captures the result and holds it until the consumer accepts it.
module alu_arbiter #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [3:0]  a0,
   input  logic [3:0]  b0,
   input  logic [3:0]  a1,
   input  logic [3:0]  b1,
   input  logic        cin0,
   input  logic        cin1,
   input  logic [2:0]  op0,
   input  logic [2:0]  op1,
   output logic        ack0,
   output logic        ack1,
   output logic [3:0]  alu_a,
   output logic [3:0]  alu_b,
   output logic        alu_cin,
   output logic [2:0]  alu_op,
   input  logic [11:0] alu_bcd,
   input  logic        alu_cout,
   input  logic        alu_ovf,
   output logic        rvalid,
   output logic        rid,
   output logic [11:0] rbcd,
   output logic        rcout,
   output logic        rovf,
   input  logic        rready
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

   logic [1:0]  r_state;
   logic [3:0]  r_cnt;
   logic        r_last;
   logic        r_ack0;
   logic        r_ack1;
   logic [3:0]  r_a;
   logic [3:0]  r_b;
   logic        r_cin;
   logic [2:0]  r_op;
   logic        r_rvalid;
   logic        r_rid;
   logic [11:0] r_rbcd;
   logic        r_rcout;
   logic        r_rovf;

   logic        w_any_req;
   logic        w_winner;

   // Winner: the sole requester, or the one not granted last when both ask.
   always_comb begin
      w_any_req = req0 | req1;
      w_winner  = (req0 & req1) ? ~r_last : req1;
   end

   // Grant / settle / hold sequencing; every output is a register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_last   <= 1'b1;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_cin    <= 1'b0;
         r_op     <= '0;
         r_rvalid <= 1'b0;
         r_rid    <= 1'b0;
         r_rbcd   <= '0;
         r_rcout  <= 1'b0;
         r_rovf   <= 1'b0;
      end else begin
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_a     <= w_winner ? a1 : a0;
                  r_b     <= w_winner ? b1 : b0;
                  r_cin   <= w_winner ? cin1 : cin0;
                  r_op    <= w_winner ? op1 : op0;
                  r_ack0  <= ~w_winner;
                  r_ack1  <= w_winner;
                  r_last  <= w_winner;
                  r_cnt   <= LP_SETTLE;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               // The edge that takes the counter to zero is the capture edge.
               if (r_cnt <= 4'd1) begin
                  r_rbcd   <= alu_bcd;
                  r_rcout  <= alu_cout;
                  r_rovf   <= alu_ovf;
                  r_rid    <= r_last;
                  r_rvalid <= 1'b1;
                  r_state  <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (rready) begin
                  r_rvalid <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ack0    = r_ack0;
   assign ack1    = r_ack1;
   assign alu_a   = r_a;
   assign alu_b   = r_b;
   assign alu_cin = r_cin;
   assign alu_op  = r_op;
   assign rvalid  = r_rvalid;
   assign rid     = r_rid;
   assign rbcd    = r_rbcd;
   assign rcout   = r_rcout;
   assign rovf    = r_rovf;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (SETTLE_CYCLES 1 and 3) share stimulus;
// a transaction-level model predicts each instance's outputs every cycle.
module tb_alu_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, req0, req1, cin0, cin1, rready, alu_cout, alu_ovf;
   logic [3:0]  a0, b0, a1, b1;
   logic [2:0]  op0, op1;
   logic [11:0] alu_bcd;

   logic        d_ack0[2], d_ack1[2], d_cin[2], d_rvalid[2], d_rid[2], d_rcout[2], d_rovf[2];
   logic [3:0]  d_a[2], d_b[2];
   logic [2:0]  d_op[2];
   logic [11:0] d_rbcd[2];

   int ncmp = 0;
   int nerr = 0;

   alu_arbiter #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin0(cin0), .cin1(cin1), .op0(op0), .op1(op1),
      .ack0(d_ack0[0]), .ack1(d_ack1[0]), .alu_a(d_a[0]), .alu_b(d_b[0]),
      .alu_cin(d_cin[0]), .alu_op(d_op[0]),
      .alu_bcd(alu_bcd), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
      .rvalid(d_rvalid[0]), .rid(d_rid[0]), .rbcd(d_rbcd[0]), .rcout(d_rcout[0]), .rovf(d_rovf[0]),
      .rready(rready)
   );

   alu_arbiter #(.SETTLE_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin0(cin0), .cin1(cin1), .op0(op0), .op1(op1),
      .ack0(d_ack0[1]), .ack1(d_ack1[1]), .alu_a(d_a[1]), .alu_b(d_b[1]),
      .alu_cin(d_cin[1]), .alu_op(d_op[1]),
      .alu_bcd(alu_bcd), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
      .rvalid(d_rvalid[1]), .rid(d_rid[1]), .rbcd(d_rbcd[1]), .rcout(d_rcout[1]), .rovf(d_rovf[1]),
      .rready(rready)
   );

   // ---------------- behavioural model ----------------
   int          m_settle[2] = '{1, 3};
   logic        m_last[2], m_busy[2], m_owner[2], m_w;
   int          m_age[2];
   logic        e_ack0[2], e_ack1[2], e_cin[2], e_rvalid[2], e_rid[2], e_rcout[2], e_rovf[2];
   logic [3:0]  e_a[2], e_b[2];
   logic [2:0]  e_op[2];
   logic [11:0] e_rbcd[2];

   // Per edge: idle -> grant; busy -> count cycles since grant and capture at
   // exactly SETTLE cycles; result pending -> release on rready.
   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_last[k] = 1'b1; m_busy[k] = 1'b0; m_owner[k] = 1'b0; m_age[k] = 0;
            e_ack0[k] = 1'b0; e_ack1[k] = 1'b0; e_a[k] = '0; e_b[k] = '0; e_cin[k] = 1'b0;
            e_op[k] = '0; e_rvalid[k] = 1'b0; e_rid[k] = 1'b0; e_rbcd[k] = '0;
            e_rcout[k] = 1'b0; e_rovf[k] = 1'b0;
         end else begin
            e_ack0[k] = 1'b0;
            e_ack1[k] = 1'b0;
            if (!m_busy[k]) begin
               if (req0 || req1) begin
                  if (req0 && req1) m_w = (m_last[k] == 1'b0) ? 1'b1 : 1'b0;
                  else              m_w = req1;
                  if (m_w) begin
                     e_a[k] = a1; e_b[k] = b1; e_cin[k] = cin1; e_op[k] = op1; e_ack1[k] = 1'b1;
                  end else begin
                     e_a[k] = a0; e_b[k] = b0; e_cin[k] = cin0; e_op[k] = op0; e_ack0[k] = 1'b1;
                  end
                  m_last[k] = m_w; m_owner[k] = m_w; m_busy[k] = 1'b1; m_age[k] = 0;
               end
            end else if (!e_rvalid[k]) begin
               m_age[k] = m_age[k] + 1;
               if (m_age[k] == m_settle[k]) begin
                  e_rbcd[k] = alu_bcd; e_rcout[k] = alu_cout; e_rovf[k] = alu_ovf;
                  e_rid[k] = m_owner[k]; e_rvalid[k] = 1'b1;
               end
            end else if (rready) begin
               e_rvalid[k] = 1'b0;
               m_busy[k] = 1'b0;
            end
         end
      end
   end

   function automatic logic [29:0] dut_vec(input int k);
      return {d_ack0[k], d_ack1[k], d_a[k], d_b[k], d_cin[k], d_op[k],
              d_rvalid[k], d_rid[k], d_rbcd[k], d_rcout[k], d_rovf[k]};
   endfunction

   function automatic logic [29:0] exp_vec(input int k);
      return {e_ack0[k], e_ack1[k], e_a[k], e_b[k], e_cin[k], e_op[k],
              e_rvalid[k], e_rid[k], e_rbcd[k], e_rcout[k], e_rovf[k]};
   endfunction

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         ncmp++;
         if (dut_vec(k) !== exp_vec(k)) begin
            nerr++;
            $display("FAIL model_cmp inst%0d t=%0t got=%h expected=%h (ack0,ack1,a,b,cin,op,rvalid,rid,rbcd,rcout,rovf)",
                     k, $time, dut_vec(k), exp_vec(k));
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, got, exp);
      end
   endtask

   logic q_ack[$];
   int   cnt;

   initial begin
      rst = 1'b1; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
      cin0 = 0; cin1 = 0; op0 = 0; op1 = 0; rready = 0;
      alu_bcd = '0; alu_cout = 0; alu_ovf = 0;
      repeat (2) @(negedge clk);
      chk("reset_outs_s1", 32'(dut_vec(0)), 32'd0);
      chk("reset_outs_s3", 32'(dut_vec(1)), 32'd0);
      rst = 1'b0;

      // Single request with fixed ALU response, then backpressure.
      req0 = 1; a0 = 4'b1100; b0 = 4'b1100; cin0 = 0; op0 = 3'b010;
      alu_bcd = 12'h024; alu_cout = 1; alu_ovf = 1;
      @(negedge clk);
      chk("single_ack0", 32'(d_ack0[0]), 32'd1);
      chk("single_ack1", 32'(d_ack1[0]), 32'd0);
      chk("single_alu_a", 32'(d_a[0]), 32'hC);
      chk("single_alu_b", 32'(d_b[0]), 32'hC);
      chk("single_alu_op", 32'(d_op[0]), 32'd2);
      chk("single_rvalid_c1", 32'(d_rvalid[0]), 32'd0);
      req0 = 0; req1 = 1; a1 = 4'h3; b1 = 4'h5; op1 = 3'b101;
      @(negedge clk);
      chk("single_rvalid_c2", 32'(d_rvalid[0]), 32'd1);
      chk("single_result", 32'({d_rid[0], d_rbcd[0], d_rcout[0], d_rovf[0]}), 32'h00093);
      chk("s3_rvalid_c2", 32'(d_rvalid[1]), 32'd0);
      alu_bcd = 12'h555;
      @(negedge clk);
      chk("s3_rvalid_c3", 32'(d_rvalid[1]), 32'd0);
      alu_bcd = 12'h999;
      @(negedge clk);
      chk("s3_rvalid_c4", 32'(d_rvalid[1]), 32'd1);
      chk("s3_final_edge_capture", 32'(d_rbcd[1]), 32'h999);
      repeat (3) @(negedge clk);
      chk("bp_hold_rbcd", 32'(d_rbcd[0]), 32'h024);
      chk("bp_hold_rvalid", 32'(d_rvalid[0]), 32'd1);
      rready = 1;
      @(negedge clk);
      chk("bp_release", 32'({d_rvalid[0], d_rvalid[1]}), 32'd0);
      @(negedge clk);
      chk("bp_req1_granted", 32'({d_ack1[0], d_ack1[1]}), 32'd3);
      req1 = 0;
      repeat (6) @(negedge clk);

      // Contention: grants must alternate, starting with requester 0.
      req0 = 1; req1 = 1;
      repeat (30) begin
         @(negedge clk);
         if (d_ack0[0]) q_ack.push_back(1'b0);
         if (d_ack1[0]) q_ack.push_back(1'b1);
      end
      req0 = 0; req1 = 0;
      chk("contend_count", 32'(q_ack.size()), 32'd10);
      chk("contend_first", (q_ack.size() > 0) ? 32'(q_ack[0]) : 32'hFF, 32'd0);
      cnt = 0;
      for (int i = 1; i < q_ack.size(); i++) if (q_ack[i] == q_ack[i-1]) cnt++;
      chk("contend_alternate", 32'(cnt), 32'd0);
      repeat (6) @(negedge clk);

      // Dropped request: req1 only while both instances are busy.
      req0 = 1;
      @(negedge clk);
      chk("drop_ack0", 32'({d_ack0[0], d_ack0[1]}), 32'd3);
      req0 = 0; req1 = 1;
      @(negedge clk);
      req1 = 0;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (d_ack1[0] || d_ack1[1]) cnt++;
      end
      chk("drop_no_ack1", 32'(cnt), 32'd0);

      // Asynchronous reset in the middle of an operation.
      req0 = 1;
      @(negedge clk);
      chk("arst_grant", 32'(d_ack0[1]), 32'd1);
      req0 = 0;
      @(negedge clk);
      #2 rst = 1;
      #1;
      chk("arst_outs_s1", 32'(dut_vec(0)), 32'd0);
      chk("arst_outs_s3", 32'(dut_vec(1)), 32'd0);
      rst = 0;
      cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (d_rvalid[0] || d_rvalid[1]) cnt++;
      end
      chk("arst_no_rvalid", 32'(cnt), 32'd0);
      req1 = 1; a1 = 4'h7;
      @(negedge clk);
      chk("arst_then_req1", 32'({d_ack1[0], d_ack1[1], d_a[0]}), 32'h37);
      req1 = 0;
      repeat (6) @(negedge clk);

      // Randomised traffic, including occasional asynchronous resets.
      repeat (3000) begin
         @(negedge clk);
         req0 = ($urandom_range(0, 2) != 0);
         req1 = ($urandom_range(0, 2) != 0);
         a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
         cin0 = 1'($urandom); cin1 = 1'($urandom);
         op0 = 3'($urandom); op1 = 3'($urandom);
         alu_bcd = 12'($urandom); alu_cout = 1'($urandom); alu_ovf = 1'($urandom);
         rready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 299) == 0) begin
            #2 rst = 1;
            #1 rst = 0;
         end
      end
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 1, number of cycles (1..15) ALU inputs are held stable before the result is captured.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-005 a0, b0, a1, b1  input  4 each  operands per requester.
REQ-006 cin0, cin1  input  1 each  carry-in per requester.
REQ-007 op0, op1  input  3 each  ALU opcode per requester.
REQ-008 ack0, ack1  output  1 each  one-cycle pulse: request accepted, operands latched.
REQ-009 alu_a, alu_b  output  4 each  to ALU A/B.
REQ-010 alu_cin  output  1  to ALU CarryIN.
REQ-011 alu_op  output  3  to ALU opCodeA.
REQ-012 alu_bcd  input  12  from ALU bcd.
REQ-013 alu_cout, alu_ovf  input  1 each  from ALU CarryOUT / overflow.
REQ-014 rvalid  output  1  result valid, held until accepted.
REQ-015 rid  output  1  requester owning the current result.
REQ-016 rbcd  output  12; rcout, rovf  output  1 each  registered result.
REQ-017 rready  input  1  consumer accepts result when rvalid&&rready.

Function
REQ-018 FSM states IDLE, WAIT, HOLD; all outputs registered.
REQ-019 IDLE: if req0 or req1 high at an edge, latch winner's a/b/cin/op, pulse winner's ack next cycle, load settle counter with SETTLE_CYCLES, go WAIT.
REQ-020 Arbitration: single requester wins; both requesting -> requester not granted last wins (round-robin); after reset requester 0 has priority.
REQ-021 last-grant pointer updates only on a grant.
REQ-022 alu_a/alu_b/alu_cin/alu_op driven from latched operands only; unchanged from grant until next grant (stable through WAIT and HOLD).
REQ-023 WAIT: counter decrements each cycle; on the edge where it reaches zero, capture alu_bcd/alu_cout/alu_ovf into rbcd/rcout/rovf, set rid, set rvalid, go HOLD.
REQ-024 Latency (SETTLE_CYCLES=1): request sampled edge 0 -> ack high cycle 1 -> rvalid high cycle 2.
REQ-025 General latency: rvalid rises SETTLE_CYCLES+1 cycles after the granting edge.
REQ-026 HOLD: rvalid and result stable until rvalid&&rready at an edge; then rvalid clears, go IDLE.
REQ-027 rready asserted while rvalid low has no effect.
REQ-028 Requests while not in IDLE are ignored, not queued; requester holds req until ack; req dropped before ack is discarded.
REQ-029 Requester whose ack pulsed starts a new operation only by holding/reasserting req; a req still high in the IDLE cycle after HOLD is granted again per REQ-020.
REQ-030 Throughput: one operation per SETTLE_CYCLES+2 cycles minimum with rready tied high.
REQ-031 ack0 and ack1 never high together; at most one ack per operation.

Reset
REQ-032 rst high forces immediately: state IDLE, ack0=ack1=0, rvalid=0, rid=0, rbcd=0, rcout=0, rovf=0, alu_a=alu_b=0, alu_cin=0, alu_op=0, counter=0, last-grant pointer=1.
REQ-033 Reset during WAIT or HOLD discards the in-flight operation; no rvalid produced for it after release.
REQ-034 First grant possible at the first rising edge after rst deasserts.

Verification
REQ-035 Single request: req0=1, a0=4'b1100, b0=4'b1100, cin0=0, op0=3'b010, bench ALU returns alu_bcd=12'h024, cout=1, ovf=1 -> ack0 cycle 1, alu_a=alu_b=1100, alu_op=010, rvalid cycle 2 with rid=0, rbcd=12'h024, rcout=1, rovf=1.
REQ-036 Contention: req0=req1=1 continuously, rready=1 -> grants alternate 0,1,0,1 starting with 0; never both acks.
REQ-037 Backpressure: rready=0 for 5 cycles after rvalid -> rvalid, rid, rbcd stable; req1 ignored; rready=1 -> rvalid drops next cycle, req1 granted next IDLE.
REQ-038 SETTLE_CYCLES=3: alu inputs change at bench ALU only at grant; rvalid rises 4 cycles after granting edge; capture uses value on alu_bcd at the final WAIT edge.
REQ-039 Async reset mid-WAIT: rst pulsed asynchronously between edges -> all outputs zero immediately, no rvalid afterwards, next req1 only request granted normally.
REQ-040 Dropped request: req1 high while in WAIT then low before IDLE -> no ack1, no operation for requester 1.
